de1_soc_switch_debounce: RTL and testbench

//   Conditions the raw DE1-SoC slide-switch pins before they reach the switches PIO in_port.
//   - 2-flop synchronizer per bit, then per-bit time-based debounce.
//   - Outputs a clean level bus (sw_db -> PIO in_port) plus one-cycle rise/fall/change strobes for interrupt or edge-capture logic.

---
 rtl/de1_soc_io_pkg.sv | 22 ++
 rtl/switch_debounce_bit.sv | 51 +++++
 rtl/de1_soc_switch_debounce.sv | 86 ++++++++
 tb/tb_de1_soc_switch_debounce.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/de1_soc_io_pkg.sv
// ============================================================================
// de1_soc_io_pkg : board defaults shared by the DE1-SoC I/O conditioning blocks
// Revision 1.0
// ============================================================================
`default_nettype none

package de1_soc_io_pkg;

  localparam int SW_WIDTH              = 10;
  localparam int DEBOUNCE_CLK_HZ       = 50_000_000;
  localparam int DEBOUNCE_SAMPLE_HZ    = 1_000;
  localparam int DEBOUNCE_STABLE_TICKS = 8;

  // A zero sample rate yields 0 so the elaboration guard fires instead of a divide fault.
  function automatic int debounce_div(input int clk_hz, input int sample_hz);
    if (sample_hz < 1) return 0;
    return clk_hz / sample_hz;
  endfunction

endpackage

`default_nettype wire

// File: rtl/switch_debounce_bit.sv
// ============================================================================
// switch_debounce_bit : per-bit tick-count debounce with registered edge strobes
// Revision 1.0
// ============================================================================
`default_nettype none

module switch_debounce_bit #(
  parameter int STABLE_TICKS = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic s,
  output logic db,
  output logic rise,
  output logic fall
);

  localparam int              CW   = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0]   LAST = CW'(STABLE_TICKS - 1);

  logic [CW-1:0] c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c    <= '0;
      db   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      // Any sample agreeing with the accepted level restarts the count, tick or not.
      if (s == db) begin
        c <= '0;
      end else if (tick) begin
        if (c == LAST) begin
          db   <= s;
          c    <= '0;
          rise <= s;
          fall <= ~s;
        end else begin
          c <= c + CW'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/de1_soc_switch_debounce.sv
// ============================================================================
// de1_soc_switch_debounce : synchronise and debounce the slide switches for the PIO
// Revision 1.0
// ============================================================================
`default_nettype none

module de1_soc_switch_debounce
  import de1_soc_io_pkg::*;
#(
  parameter int WIDTH        = SW_WIDTH,
  parameter int CLK_HZ       = DEBOUNCE_CLK_HZ,
  parameter int SAMPLE_HZ    = DEBOUNCE_SAMPLE_HZ,
  parameter int STABLE_TICKS = DEBOUNCE_STABLE_TICKS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed
);

  localparam int DIV = debounce_div(CLK_HZ, SAMPLE_HZ);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic             tick;

  if (STABLE_TICKS < 1) begin : g_bad_stable
    $error("de1_soc_switch_debounce: STABLE_TICKS must be >= 1");
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  if (DIV < 1) begin : g_bad_div
    $error("de1_soc_switch_debounce: CLK_HZ/SAMPLE_HZ must be >= 1");
    assign tick = 1'b0;
  end else if (DIV == 1) begin : g_tick_always
    assign tick = 1'b1;
  end else begin : g_prescaler
    localparam int            PW   = $clog2(DIV);
    localparam logic [PW-1:0] WRAP = PW'(DIV - 1);
    logic [PW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
      end else if (cnt == WRAP) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + PW'(1);
      end
    end

    assign tick = (cnt == WRAP);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .tick   (tick),
      .s      (s2[i]),
      .db     (sw_db[i]),
      .rise   (sw_rise[i]),
      .fall   (sw_fall[i])
    );
  end

  // Built only from registered strobes, so it is glitch-free and cycle-aligned with them.
  assign changed = |(sw_rise | sw_fall);

endmodule

`default_nettype wire

// File: tb/tb_de1_soc_switch_debounce.sv
// ============================================================================
// tb_de1_soc_switch_debounce : directed stimulus checked against a tick-run model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_de1_soc_switch_debounce;

  localparam int W      = 10;
  localparam int CLKHZ  = 100;
  localparam int SMPHZ  = 10;
  localparam int DIV    = CLKHZ / SMPHZ;
  localparam int STABLE = 3;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_db, sw_rise, sw_fall;
  logic         changed;

  int n_checks = 0;
  int n_errors = 0;

  de1_soc_switch_debounce #(
    .WIDTH(W), .CLK_HZ(CLKHZ), .SAMPLE_HZ(SMPHZ), .STABLE_TICKS(STABLE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw),
    .sw_db(sw_db), .sw_rise(sw_rise), .sw_fall(sw_fall), .changed(changed)
  );

  always #5 clk = ~clk;

  // Model: a bit flips on the STABLE-th sample tick of an unbroken run of
  // disagreement between the 2-cycle-delayed input and the accepted level.
  logic [W-1:0] m_s1 = '0, m_s2 = '0, m_db = '0, m_rise = '0, m_fall = '0;
  int           m_edges = 0;
  int           m_run [W];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0; m_edges = 0;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      bit is_tick;
      is_tick = (m_edges % DIV) == DIV - 1;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < W; i++) begin
        if (m_s2[i] == m_db[i]) begin
          m_run[i] = 0;
        end else if (is_tick) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == STABLE) begin
            m_db[i]   = m_s2[i];
            m_rise[i] = m_s2[i];
            m_fall[i] = !m_s2[i];
            m_run[i]  = 0;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = sw_raw;
      m_edges++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string nm, input int n, input int lo, input int hi);
    n_checks++;
    if (n < lo || n > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d cycles expected %0d..%0d", nm, n, lo, hi);
    end
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic step();
    @(negedge clk);
    chk("model_db",      32'(sw_db),   32'(m_db));
    chk("model_rise",    32'(sw_rise), 32'(m_rise));
    chk("model_fall",    32'(sw_fall), 32'(m_fall));
    chk("model_changed", 32'(changed), 32'(|(m_rise | m_fall)));
  endtask

  task automatic wait_db(input logic [W-1:0] mask, input logic [W-1:0] val, output int n);
    n = 0;
    while ((sw_db & mask) != val && n < 60) begin
      step();
      n++;
    end
    if ((sw_db & mask) != val) chk("wait_timeout", 32'(sw_db & mask), 32'(val));
  endtask

  initial begin
    int n;
    // 1: reset with all switches up
    sw_raw = 10'h3FF;
    repeat (3) step();
    chk("reset_db", 32'(sw_db), 32'h0);
    chk("reset_changed", 32'(changed), 32'h0);
    reset_n = 1'b1;
    wait_db(10'h3FF, 10'h3FF, n);
    chk_range("t1_latency", n, 23, 32);
    chk("t1_rise", 32'(sw_rise), 32'h3FF);
    chk("t1_changed", 32'(changed), 32'h1);
    step();
    chk("t1_rise_clear", 32'(sw_rise), 32'h0);
    chk("t1_changed_clear", 32'(changed), 32'h0);

    // 2: drop everything, then a clean step on bit 0
    sw_raw = '0;
    wait_db(10'h3FF, 10'h000, n);
    repeat (3) step();
    sw_raw = 10'h001;
    wait_db(10'h001, 10'h001, n);
    chk_range("t2_latency", n, 23, 32);
    chk("t2_rise", 32'(sw_rise), 32'h001);
    chk("t2_fall", 32'(sw_fall), 32'h0);
    step();
    chk("t2_rise_clear", 32'(sw_rise), 32'h0);

    // 3: bounce on bit 3 every 12 cycles, then hold high
    for (int k = 0; k < 8; k++) begin
      sw_raw[3] = ~sw_raw[3];
      repeat (12) begin
        step();
        chk("t3_db3_stays", 32'(sw_db[3]), 32'h0);
      end
    end
    sw_raw[3] = 1'b1;
    wait_db(10'h008, 10'h008, n);
    chk_range("t3_latency", n, 23, 32);
    chk("t3_rise", 32'(sw_rise), 32'h008);

    // 4: all up, then several bits fall together
    sw_raw = 10'h3FF;
    wait_db(10'h3FF, 10'h3FF, n);
    repeat (3) step();
    sw_raw = 10'h155;
    wait_db(10'h3FF, 10'h155, n);
    chk("t4_fall", 32'(sw_fall), 32'h2AA);
    chk("t4_rise", 32'(sw_rise), 32'h0);
    chk("t4_changed", 32'(changed), 32'h1);
    step();
    chk("t4_changed_once", 32'(changed), 32'h0);

    // 5: one-cycle glitch on bit 5 timed so its synced sample lands on a tick
    while ((m_edges + 2) % DIV != DIV - 1) step();
    sw_raw[5] = 1'b1;
    step();
    sw_raw[5] = 1'b0;
    repeat (40) step();
    chk("t5_db_unchanged", 32'(sw_db), 32'h155);
    sw_raw[5] = 1'b1;
    wait_db(10'h020, 10'h020, n);
    chk_range("t5_full_restart", n, 23, 32);

    // 6: reset partway through a debounce of bit 2
    sw_raw[2] = 1'b0;
    repeat (15) step();
    #2 reset_n = 1'b0;
    #1;
    chk("t6_db_async", 32'(sw_db), 32'h0);
    chk("t6_strobes_async", 32'(sw_rise | sw_fall), 32'h0);
    chk("t6_changed_async", 32'(changed), 32'h0);
    repeat (3) step();
    reset_n = 1'b1;
    wait_db(10'h3FF, 10'h171, n);
    chk_range("t6_latency", n, 23, 32);
    chk("t6_rise", 32'(sw_rise), 32'h171);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
